// File: rtl/button_bank_debounce.sv
// Multi-channel push-button conditioner: sync, debounce, press/release,
// click, long-press and auto-repeat events per independent channel.
module button_bank_debounce #(
  parameter int              N_CH       = 4,
  parameter int              CNT_W      = 32,
  parameter int              DEBOUNCE   = 5_000,
  parameter int              LONG_PRESS = 50_000_000,
  parameter int              REPEAT     = 10_000_000,
  parameter logic [N_CH-1:0] ACTIVE_LOW = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N_CH-1:0] i_button,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_click,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [N_CH-1:0] raw;
  assign raw = i_button ^ ACTIVE_LOW;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             level;
    logic             long_done;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] rcnt;
    logic             press_q;
    logic             release_q;
    logic             click_q;
    logic             long_q;
    logic             repeat_q;
    logic             accept;
    logic             rise;
    logic             fall;
    logic             hold;

    // A falling edge suppresses hold tracking so click and long never meet.
    always_comb begin
      accept = (s2 != level) && (dcnt == DB_LAST);
      rise   = accept && s2;
      fall   = accept && !s2;
      hold   = level && !fall;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        level     <= 1'b0;
        long_done <= 1'b0;
        dcnt      <= '0;
        hcnt      <= '0;
        rcnt      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        click_q   <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        s1        <= raw[g];
        s2        <= s1;
        press_q   <= rise;
        release_q <= fall;
        click_q   <= fall && !long_done;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;

        if (s2 == level) begin
          dcnt <= '0;
        end else if (accept) begin
          level <= s2;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + ONE;
        end

        if (rise) begin
          hcnt      <= '0;
          rcnt      <= '0;
          long_done <= 1'b0;
        end else if (hold) begin
          if (hcnt != LP_MAX) hcnt <= hcnt + ONE;
          if (hcnt == LP_LAST) begin
            long_q    <= 1'b1;
            long_done <= 1'b1;
            rcnt      <= '0;
          end else if (long_done) begin
            if (!i_repeat_en[g]) begin
              rcnt <= '0;
            end else if (rcnt == RP_LAST) begin
              repeat_q <= 1'b1;
              rcnt     <= '0;
            end else begin
              rcnt <= rcnt + ONE;
            end
          end
        end else begin
          hcnt <= '0;
          rcnt <= '0;
        end
      end
    end

    assign o_level[g]   = level;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_click[g]   = click_q;
    assign o_long[g]    = long_q;
    assign o_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_button_bank_debounce.sv
// Directed bench for button_bank_debounce: glitch rejection, click,
// long/repeat timing, active-low channel and asynchronous reset.
module tb_button_bank_debounce;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [1:0] i_button = 2'b10;
  logic [1:0] i_repeat_en = 2'b00;
  logic [1:0] o_level;
  logic [1:0] o_press;
  logic [1:0] o_release;
  logic [1:0] o_click;
  logic [1:0] o_long;
  logic [1:0] o_repeat;

  button_bank_debounce #(
    .N_CH       (2),
    .CNT_W      (8),
    .DEBOUNCE   (4),
    .LONG_PRESS (20),
    .REPEAT     (8),
    .ACTIVE_LOW (2'b10)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_button    (i_button),
    .i_repeat_en (i_repeat_en),
    .o_level     (o_level),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_click     (o_click),
    .o_long      (o_long),
    .o_repeat    (o_repeat)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int np[2]   = '{0, 0};
  int nr[2]   = '{0, 0};
  int nc[2]   = '{0, 0};
  int nl[2]   = '{0, 0};
  int tp[2]   = '{0, 0};
  int tr[2]   = '{0, 0};
  int tc[2]   = '{0, 0};
  int tl[2]   = '{0, 0};
  int rq[2][$];
  int ncoin = 0;

  // Event log sampled mid-cycle; timestamps are the edge index.
  always @(negedge i_clk) begin
    for (int c = 0; c < 2; c++) begin
      if (o_press[c])   begin np[c] <= np[c] + 1; tp[c] <= cyc; end
      if (o_release[c]) begin nr[c] <= nr[c] + 1; tr[c] <= cyc; end
      if (o_click[c])   begin nc[c] <= nc[c] + 1; tc[c] <= cyc; end
      if (o_long[c])    begin nl[c] <= nl[c] + 1; tl[c] <= cyc; end
      if (o_repeat[c])  rq[c].push_back(cyc);
      if (int'(o_click[c]) + int'(o_long[c]) + int'(o_repeat[c]) > 1)
        ncoin <= ncoin + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic int rep_at(input int c, input int i);
    if (i < rq[c].size()) return rq[c][i];
    return -1;
  endfunction

  int c0, p, q, sp, sr, sc, sl;

  initial begin
    tick(3);
    chk("reset_outs", int'({o_level, o_press, o_release,
                            o_click, o_long, o_repeat}), 0);
    i_reset = 1'b0;
    tick(50);
    chk("idle_outs", int'({o_level, o_press, o_release,
                           o_click, o_long, o_repeat}), 0);
    chk("idle_events", np[0] + np[1] + nr[0] + nr[1], 0);
    #2 i_reset = 1'b1;
    #1 chk("async_rst_idle", int'(o_level), 0);
    tick(2);
    i_reset = 1'b0;
    tick(3);

    // ch0 glitches of 3 cycles, then steady press
    for (int i = 0; i < 4; i++) begin
      i_button = (i % 2 == 0) ? 2'b11 : 2'b10;
      tick(3);
    end
    tick(4);
    chk("glitch_press", np[0], 0);
    chk("glitch_level", int'(o_level[0]), 0);
    i_button = 2'b11;
    c0 = cyc;
    tick(8);
    chk("press_cnt", np[0], 1);
    chk("press_time", tp[0], c0 + 6);
    chk("press_level", int'(o_level[0]), 1);

    // short hold then release: click
    p = tp[0];
    tick(p + 10 - cyc);
    i_button = 2'b10;
    tick(10);
    chk("click_rel_cnt", nr[0], 1);
    chk("click_cnt", nc[0], 1);
    chk("click_rel_time", tr[0], p + 16);
    chk("click_time", tc[0], p + 16);
    chk("click_no_long", nl[0], 0);
    chk("click_level", int'(o_level[0]), 0);

    // long hold with repeat enabled
    i_repeat_en = 2'b01;
    i_button = 2'b11;
    c0 = cyc;
    tick(8);
    chk("lp_press_time", tp[0], c0 + 6);
    p = tp[0];
    tick(p + 45 - cyc);
    i_button = 2'b10;
    tick(10);
    chk("lp_long_cnt", nl[0], 1);
    chk("lp_long_time", tl[0], p + 20);
    chk("lp_rep_cnt", rq[0].size(), 3);
    chk("lp_rep0", rep_at(0, 0), p + 28);
    chk("lp_rep1", rep_at(0, 1), p + 36);
    chk("lp_rep2", rep_at(0, 2), p + 44);
    chk("lp_rel_time", tr[0], p + 51);
    chk("lp_no_click", nc[0], 1);
    i_repeat_en = 2'b00;

    // ch1 active-low, repeat disabled at +30
    sp = np[0];
    sr = nr[0];
    i_repeat_en = 2'b10;
    i_button = 2'b00;
    c0 = cyc;
    tick(8);
    chk("ch1_press_cnt", np[1], 1);
    chk("ch1_press_time", tp[1], c0 + 6);
    q = tp[1];
    tick(q + 29 - cyc);
    i_repeat_en = 2'b00;
    tick(q + 60 - cyc);
    i_button = 2'b10;
    tick(10);
    chk("ch1_long_time", tl[1], q + 20);
    chk("ch1_rep_cnt", rq[1].size(), 1);
    chk("ch1_rep0", rep_at(1, 0), q + 28);
    chk("ch1_rel_time", tr[1], q + 66);
    chk("ch1_no_click", nc[1], 0);
    chk("ch0_quiet", (np[0] - sp) + (nr[0] - sr), 0);

    // reset during a ch0 hold
    i_button = 2'b11;
    c0 = cyc;
    tick(8);
    chk("rst_press_time", tp[0], c0 + 6);
    p = tp[0];
    tick(p + 15 - cyc);
    sp = np[0];
    sr = nr[0];
    sc = nc[0];
    sl = nl[0];
    #2 i_reset = 1'b1;
    #1 chk("rst_level_async", int'(o_level[0]), 0);
    tick(2);
    i_reset = 1'b0;
    c0 = cyc;
    tick(8);
    chk("rst_no_rel", nr[0] - sr, 0);
    chk("rst_no_click", nc[0] - sc, 0);
    chk("rst_no_long", nl[0] - sl, 0);
    chk("rst_repress_cnt", np[0] - sp, 1);
    chk("rst_repress_time", tp[0], c0 + 6);
    chk("no_coincide", ncoin, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
